// File: rtl/multicycle_processor_param.sv
// Parametrised multicycle core: external 1-cycle ROM, single internal bus, 8-opcode ISA.
// Register file, A/G operand latches, PC and IR; FSM walks FETCH/DECODE/EX1..EX3 or parks in HALT.
module multicycle_processor_param #(
    parameter int  DATA_WIDTH = 16,
    parameter int  NUM_REGS   = 8,
    parameter int  ADDR_WIDTH = 8,
    localparam int REG_BITS   = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic [REG_BITS-1:0]   reg_sel,
    output logic [DATA_WIDTH-1:0] reg_out,
    output logic [DATA_WIDTH-1:0] bus,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  halted,
    output logic                  zero
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EX1 = 3'd2, EX2 = 3'd3, EX3 = 3'd4, HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_MV = 3'd0, OP_MVI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
        OP_XOR = 3'd4, OP_AND = 3'd5, OP_JNZ = 3'd6, OP_HALT = 3'd7
    } op_t;

    // Only the opcode and register fields are kept; the low instruction bits are don't-care.
    typedef struct packed {
        op_t                op;
        logic [REG_BITS-1:0] rx;
        logic [REG_BITS-1:0] ry;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    state_t                               cur, nxt;
    dec_t                                 ir;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  rf;
    logic [DATA_WIDTH-1:0]                a, g, alu;
    logic [ADDR_WIDTH-1:0]                pc;
    logic                                 rf_we, a_ld, g_ld, z_ld, ir_ld, pc_inc, pc_ld;
    op_t                                  fetched_op;

    assign fetched_op = op_t'(instr_data[DATA_WIDTH-1 -: 3]);
    assign pc_addr    = pc;
    assign reg_out    = rf[reg_sel];
    assign state      = cur;
    assign halted     = (cur == HALT);

    always_comb begin
        alu = '0;
        case (ir.op)
            OP_ADD:  alu = a + rf[ir.ry];
            OP_SUB:  alu = a - rf[ir.ry];
            OP_XOR:  alu = a ^ rf[ir.ry];
            OP_AND:  alu = a & rf[ir.ry];
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Every register-file and A write is sourced from the bus, so bus drive and write enable go together.
    always_comb begin
        nxt    = cur;
        bus    = '0;
        done   = 1'b0;
        rf_we  = 1'b0;
        a_ld   = 1'b0;
        g_ld   = 1'b0;
        z_ld   = 1'b0;
        ir_ld  = 1'b0;
        pc_inc = 1'b0;
        pc_ld  = 1'b0;
        case (cur)
            FETCH: begin
                if (run) begin
                    pc_inc = 1'b1;
                    nxt    = DECODE;
                end
            end
            DECODE: begin
                ir_ld = 1'b1;
                nxt   = (fetched_op == OP_HALT) ? HALT : EX1;
            end
            EX1: begin
                case (ir.op)
                    OP_MV: begin
                        bus   = rf[ir.ry];
                        rf_we = 1'b1;
                        done  = 1'b1;
                        nxt   = FETCH;
                    end
                    OP_MVI, OP_JNZ: begin
                        pc_inc = 1'b1;
                        nxt    = EX2;
                    end
                    default: begin
                        bus  = rf[ir.rx];
                        a_ld = 1'b1;
                        nxt  = EX2;
                    end
                endcase
            end
            EX2: begin
                case (ir.op)
                    OP_MVI: begin
                        bus   = instr_data;
                        rf_we = 1'b1;
                        done  = 1'b1;
                        nxt   = FETCH;
                    end
                    OP_JNZ: begin
                        pc_ld = (rf[ir.rx] != '0);
                        done  = 1'b1;
                        nxt   = FETCH;
                    end
                    default: begin
                        g_ld = 1'b1;
                        nxt  = EX3;
                    end
                endcase
            end
            EX3: begin
                bus   = g;
                rf_we = 1'b1;
                z_ld  = 1'b1;
                done  = 1'b1;
                nxt   = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf   <= '0;
            a    <= '0;
            g    <= '0;
            ir   <= '0;
            pc   <= '0;
            zero <= 1'b0;
        end else begin
            if (rf_we) rf[ir.rx] <= bus;
            if (a_ld)  a <= bus;
            if (g_ld)  g <= alu;
            if (z_ld)  zero <= (g == '0);
            if (ir_ld) ir <= dec_t'(instr_data[DATA_WIDTH-1 -: DEC_W]);
            if (pc_ld)       pc <= instr_data[ADDR_WIDTH-1:0];
            else if (pc_inc) pc <= pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_processor_param.sv
// Directed bench: default-parameter core plus an ADDR_WIDTH=4 / NUM_REGS=16 core, each fed by a modelled sync ROM.
// Cycle indices count from 0 = first FETCH cycle after reset release.
module tb_multicycle_processor_param;
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, run = 1'b0;
    logic [15:0] instr_data;
    logic [7:0]  pc_addr;
    logic [2:0]  reg_sel = '0;
    logic [15:0] reg_out, bus;
    logic [2:0]  state;
    logic        done, halted, zero;

    logic        reset2 = 1'b1, run2 = 1'b0;
    logic [15:0] instr_data2;
    logic [3:0]  pc_addr2;
    logic [3:0]  reg_sel2 = '0;
    logic [15:0] reg_out2, bus2;
    logic [2:0]  state2;
    logic        done2, halted2, zero2;

    logic [15:0] rom0 [0:255];
    logic [15:0] rom1 [0:15];

    int checks = 0;
    int failures = 0;

    always @(posedge clock) instr_data  <= rom0[pc_addr];
    always @(posedge clock) instr_data2 <= rom1[pc_addr2];

    multicycle_processor_param dut0 (
        .clock(clock), .reset(reset), .run(run), .instr_data(instr_data), .pc_addr(pc_addr),
        .reg_sel(reg_sel), .reg_out(reg_out), .bus(bus), .state(state), .done(done),
        .halted(halted), .zero(zero)
    );

    multicycle_processor_param #(.DATA_WIDTH(16), .NUM_REGS(16), .ADDR_WIDTH(4)) dut1 (
        .clock(clock), .reset(reset2), .run(run2), .instr_data(instr_data2), .pc_addr(pc_addr2),
        .reg_sel(reg_sel2), .reg_out(reg_out2), .bus(bus2), .state(state2), .done(done2),
        .halted(halted2), .zero(zero2)
    );

    function automatic logic [15:0] e8(input logic [2:0] op, input int rx, input int ry);
        return {op, 3'(rx), 3'(ry), 7'b0};
    endfunction

    function automatic logic [15:0] e16(input logic [2:0] op, input int rx, input int ry);
        return {op, 4'(rx), 4'(ry), 5'b0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_rom0();
        for (int i = 0; i < 256; i++) rom0[i] = 16'hE000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rd(input int n, output logic [15:0] v);
        reg_sel = 3'(n);
        #1;
        v = reg_out;
    endtask

    task automatic run_until_halt(input int max, output bit ok);
        int n = 0;
        while (!halted && n < max) begin
            tick();
            n++;
        end
        ok = halted;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        clear_rom0();
        rom0[0] = e8(3'd1, 7, 0);
        rom0[1] = 16'h55AA;
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        rd(7, v);
        checks++; if (v !== 16'h55AA) begin failures++; $display("FAIL pre_reset_r7 got=%h exp=55aa", v); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (pc_addr !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc_addr); end
        checks++; if ({done, halted, zero} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done, halted, zero}); end
        checks++; if (bus !== 16'h0) begin failures++; $display("FAIL reset_bus got=%h exp=0", bus); end
        for (int r = 0; r < 8; r++) begin
            rd(r, v);
            checks++; if (v !== 16'h0) begin failures++; $display("FAIL reset_reg r%0d got=%h exp=0", r, v); end
        end
    endtask

    task automatic test_add_prog();
        int          dc[$];
        int          halt_cyc = -1;
        logic [15:0] b0 = '1, b3 = '0, b10 = '0, b12 = '0, v;
        int          d0, d1, d2;
        clear_rom0();
        rom0[0] = e8(3'd1, 0, 0); rom0[1] = 16'd5;
        rom0[2] = e8(3'd1, 1, 0); rom0[3] = 16'd3;
        rom0[4] = e8(3'd2, 0, 1);
        rom0[5] = 16'hE000;
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (done) dc.push_back(c);
            if (halted && halt_cyc < 0) halt_cyc = c;
            if (c == 0)  b0  = bus;
            if (c == 3)  b3  = bus;
            if (c == 10) b10 = bus;
            if (c == 12) b12 = bus;
            tick();
        end
        d0 = (dc.size() > 0) ? dc[0] : -1;
        d1 = (dc.size() > 1) ? dc[1] : -1;
        d2 = (dc.size() > 2) ? dc[2] : -1;
        checks++; if (dc.size() != 3) begin failures++; $display("FAIL add_done_count got=%0d exp=3", dc.size()); end
        checks++; if (d0 != 3 || d1 != 7 || d2 != 12) begin failures++; $display("FAIL add_done_cycles got=%0d,%0d,%0d exp=3,7,12", d0, d1, d2); end
        checks++; if (halt_cyc != 15) begin failures++; $display("FAIL add_halt_cycle got=%0d exp=15", halt_cyc); end
        checks++; if (b0 !== 16'h0) begin failures++; $display("FAIL bus_fetch got=%h exp=0", b0); end
        checks++; if (b3 !== 16'd5) begin failures++; $display("FAIL bus_mvi_imm got=%h exp=5", b3); end
        checks++; if (b10 !== 16'd5) begin failures++; $display("FAIL bus_alu_ex1 got=%h exp=5", b10); end
        checks++; if (b12 !== 16'd8) begin failures++; $display("FAIL bus_alu_ex3 got=%h exp=8", b12); end
        rd(0, v);
        checks++; if (v !== 16'd8) begin failures++; $display("FAIL add_r0 got=%h exp=8", v); end
        rd(1, v);
        checks++; if (v !== 16'd3) begin failures++; $display("FAIL add_r1 got=%h exp=3", v); end
        checks++; if (!halted || state !== 3'd5 || done) begin failures++; $display("FAIL halt_sticky got=h%b s%0d d%b exp=h1 s5 d0", halted, state, done); end
        checks++; if (pc_addr !== 8'd6) begin failures++; $display("FAIL halt_pc got=%0d exp=6", pc_addr); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
    endtask

    task automatic test_sub_zero();
        logic [15:0] v;
        bit          ok;
        clear_rom0();
        rom0[0] = e8(3'd1, 1, 0); rom0[1] = 16'd1;
        rom0[2] = e8(3'd1, 2, 0); rom0[3] = 16'd1;
        rom0[4] = e8(3'd3, 2, 2);
        rom0[5] = e8(3'd3, 2, 1);
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 13; c++) tick();
        rd(2, v);
        checks++; if (v !== 16'h0) begin failures++; $display("FAIL sub_self_val got=%h exp=0", v); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL sub_self_zero got=%b exp=1", zero); end
        run_until_halt(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL sub_timeout got=not_halted exp=halted"); end
        rd(2, v);
        checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL sub_borrow got=%h exp=ffff", v); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL sub_borrow_zero got=%b exp=0", zero); end
    endtask

    task automatic test_loop();
        logic [15:0] v;
        int          subs = 0, dones = 0, n = 0;
        clear_rom0();
        rom0[0] = e8(3'd1, 3, 0); rom0[1] = 16'd3;
        rom0[2] = e8(3'd1, 4, 0); rom0[3] = 16'd1;
        rom0[4] = e8(3'd3, 3, 4);
        rom0[5] = e8(3'd6, 3, 0); rom0[6] = 16'd4;
        rom0[7] = 16'hE000;
        do_reset();
        run = 1'b1;
        while (!halted && n < 200) begin
            if (done && state == 3'd4) subs++;
            if (done) dones++;
            tick();
            n++;
        end
        checks++; if (!halted) begin failures++; $display("FAIL loop_timeout got=not_halted exp=halted"); end
        checks++; if (subs != 3) begin failures++; $display("FAIL loop_sub_count got=%0d exp=3", subs); end
        checks++; if (dones != 8) begin failures++; $display("FAIL loop_done_count got=%0d exp=8", dones); end
        rd(3, v);
        checks++; if (v !== 16'h0) begin failures++; $display("FAIL loop_r3 got=%h exp=0", v); end
        checks++; if (pc_addr !== 8'd8) begin failures++; $display("FAIL loop_pc got=%0d exp=8", pc_addr); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL loop_zero got=%b exp=1", zero); end
    endtask

    task automatic test_run_gate();
        logic [15:0] v;
        bit          saw_done = 1'b0, ok;
        clear_rom0();
        rom0[0] = e8(3'd1, 0, 0); rom0[1] = 16'd9;
        rom0[2] = e8(3'd1, 1, 0); rom0[3] = 16'd7;
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL gate_state got=%0d exp=0", state); end
        checks++; if (pc_addr !== 8'd2) begin failures++; $display("FAIL gate_pc got=%0d exp=2", pc_addr); end
        checks++; if (saw_done) begin failures++; $display("FAIL gate_done got=1 exp=0"); end
        rd(0, v);
        checks++; if (v !== 16'd9) begin failures++; $display("FAIL gate_r0 got=%h exp=9", v); end
        rd(1, v);
        checks++; if (v !== 16'd0) begin failures++; $display("FAIL gate_r1_held got=%h exp=0", v); end
        run = 1'b1;
        run_until_halt(30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL gate_timeout got=not_halted exp=halted"); end
        rd(1, v);
        checks++; if (v !== 16'd7) begin failures++; $display("FAIL gate_r1_resume got=%h exp=7", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        bit          saw_done = 1'b0;
        clear_rom0();
        rom0[0] = e8(3'd1, 6, 0); rom0[1] = 16'd4;
        rom0[2] = e8(3'd2, 5, 6);
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        for (int c = 4; c < 7; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL mid_in_ex2 got=%0d exp=3", state); end
        rd(6, v);
        checks++; if (v !== 16'd4) begin failures++; $display("FAIL mid_r6 got=%h exp=4", v); end
        if (done) saw_done = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run = 1'b0;
        checks++; if (state !== 3'd0 || pc_addr !== 8'd0) begin failures++; $display("FAIL mid_reset got=s%0d pc%0d exp=s0 pc0", state, pc_addr); end
        for (int c = 0; c < 4; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done) begin failures++; $display("FAIL mid_done got=1 exp=0"); end
        rd(5, v);
        checks++; if (v !== 16'd0) begin failures++; $display("FAIL mid_r5 got=%h exp=0", v); end
    endtask

    task automatic test_wrap_wide();
        logic [15:0] b43 = '0;
        for (int i = 0; i < 16; i++) rom1[i] = e16(3'd0, 1, 1);
        rom1[0]  = e16(3'd1, 0, 0); rom1[1]  = 16'hABCD;
        rom1[2]  = e16(3'd0, 15, 0);
        rom1[14] = e16(3'd1, 2, 0); rom1[15] = 16'h1234;
        reset2 = 1'b1;
        tick();
        tick();
        reset2 = 1'b0;
        run2 = 1'b1;
        for (int c = 0; c < 44; c++) begin
            if (c == 43) b43 = bus2;
            tick();
        end
        run2 = 1'b0;
        checks++; if (state2 !== 3'd0 || pc_addr2 !== 4'd0) begin failures++; $display("FAIL wrap_pc got=s%0d pc%0d exp=s0 pc0", state2, pc_addr2); end
        checks++; if (b43 !== 16'h1234) begin failures++; $display("FAIL wrap_imm_bus got=%h exp=1234", b43); end
        reg_sel2 = 4'd2;
        #1;
        checks++; if (reg_out2 !== 16'h1234) begin failures++; $display("FAIL wrap_r2 got=%h exp=1234", reg_out2); end
        reg_sel2 = 4'd15;
        #1;
        checks++; if (reg_out2 !== 16'hABCD) begin failures++; $display("FAIL wide_r15 got=%h exp=abcd", reg_out2); end
        checks++; if (zero2 !== 1'b0) begin failures++; $display("FAIL wide_zero got=%b exp=0", zero2); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom1[i] = 16'hE000;
        clear_rom0();
        test_reset();
        test_add_prog();
        test_sub_zero();
        test_loop();
        test_run_gate();
        test_reset_mid();
        test_wrap_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
